// File: rtl/epu_buf_pkg.sv
// Shared constants and host burst FSM encoding for the EPU buffer wrapper.
package epu_buf_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned NBANK_DEF  = 2;
  localparam int unsigned LEN_W_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } host_state_t;

endpackage

// File: rtl/epu_rd_skid.sv
// Two-entry in-order read buffer; the head entry holds still until it is popped.
module epu_rd_skid #(
  parameter int unsigned W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         valid,
  output logic [W-1:0] data,
  output logic [1:0]   count
);

  logic [W-1:0] e0_q;
  logic [W-1:0] e1_q;
  logic [1:0]   cnt_q;
  logic         pop_ok;

  assign pop_ok = pop && (cnt_q != 2'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= 2'd0;
    end else begin
      unique case ({push, pop_ok})
        2'b10: begin
          if (cnt_q == 2'd0) e0_q <= push_data;
          else               e1_q <= push_data;
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          e0_q  <= e1_q;
          cnt_q <= cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            e0_q <= push_data;
          end else begin
            e0_q <= e1_q;
            e1_q <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign valid = (cnt_q != 2'd0);
  assign data  = e0_q;
  assign count = cnt_q;

endmodule

// File: rtl/epu_buf_wrapper.sv
// Banked single-port buffer shared between a host burst port and an EPU port,
// with per-bank ownership that is never moved under an active host burst.
module epu_buf_wrapper
  import epu_buf_pkg::*;
#(
  parameter  int unsigned DATA_W = DATA_W_DEF,
  parameter  int unsigned ADDR_W = ADDR_W_DEF,
  parameter  int unsigned NBANK  = NBANK_DEF,
  parameter  int unsigned LEN_W  = LEN_W_DEF,
  localparam int unsigned BK_W   = $clog2(NBANK)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enb_i,
  input  logic                   h_req_i,
  input  logic                   h_we_i,
  input  logic [BK_W+ADDR_W-1:0] h_addr_i,
  input  logic [LEN_W-1:0]       h_len_i,
  output logic                   h_gnt_o,
  input  logic                   h_wvalid_i,
  input  logic [DATA_W-1:0]      h_wdata_i,
  output logic                   h_wready_o,
  output logic                   h_rvalid_o,
  output logic [DATA_W-1:0]      h_rdata_o,
  output logic                   h_rlast_o,
  input  logic                   h_rready_i,
  output logic                   h_done_o,
  input  logic                   e_cs_i,
  input  logic                   e_we_i,
  input  logic [BK_W+ADDR_W-1:0] e_addr_i,
  input  logic [DATA_W-1:0]      e_wdata_i,
  output logic [DATA_W-1:0]      e_rdata_o,
  output logic                   e_rvalid_o,
  output logic                   e_err_o,
  input  logic                   own_wr_i,
  input  logic [NBANK-1:0]       own_i,
  output logic [NBANK-1:0]       own_o
);

  localparam int unsigned CNT_W = LEN_W + 1;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  host_state_t state_q, state_d;

  logic [BK_W-1:0]   bk_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [CNT_W-1:0]  beat_q;
  logic              infl_q;
  logic              infl_last_q;
  logic [NBANK-1:0]  own_q;
  logic [NBANK-1:0]  pend_v_q;
  logic [NBANK-1:0]  pend_d_q;
  logic [NBANK-1:0]  busy;
  logic              e_rvalid_q;
  logic              e_err_q;
  logic [BK_W-1:0]   e_bk_q;

  logic [DATA_W-1:0] bank_rd [NBANK];
  logic [BK_W-1:0]   h_bank;
  logic [BK_W-1:0]   e_bank;
  logic              gnt;
  logic              wr_beat;
  logic              rd_issue;
  logic              rd_pop;
  logic              e_ok;
  logic              sk_valid;
  logic [DATA_W:0]   sk_data;
  logic [1:0]        sk_cnt;

  assign h_bank   = h_addr_i[BK_W+ADDR_W-1 -: BK_W];
  assign e_bank   = e_addr_i[BK_W+ADDR_W-1 -: BK_W];
  assign e_ok     = e_cs_i && own_q[e_bank];
  assign wr_beat  = (state_q == WR) && h_wvalid_i;
  // Issue only while beats remain and the buffer can absorb every outstanding read.
  assign rd_issue = (state_q == RD) && (beat_q <= CNT_W'(len_q)) &&
                    (({1'b0, sk_cnt} + {2'b00, infl_q}) < 3'd2);
  assign rd_pop   = sk_valid && h_rready_i;

  // Host burst FSM: next state and decoded handshake outputs.
  always_comb begin
    state_d    = state_q;
    gnt        = 1'b0;
    h_wready_o = 1'b0;
    h_done_o   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rst && h_req_i && enb_i && !own_q[h_bank]) begin
          gnt     = 1'b1;
          state_d = h_we_i ? WR : RD;
        end
      end
      WR: begin
        h_wready_o = 1'b1;
        if (wr_beat && (beat_q == CNT_W'(len_q))) state_d = DONE;
      end
      RD: begin
        if (rd_pop && sk_data[DATA_W]) state_d = DONE;
      end
      DONE: begin
        h_done_o = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign h_gnt_o = gnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Burst address/length/beat tracking; address wraps inside the latched bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bk_q        <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
    end else begin
      infl_q      <= rd_issue;
      infl_last_q <= rd_issue && (beat_q == CNT_W'(len_q));
      if (gnt) begin
        bk_q   <= h_bank;
        addr_q <= h_addr_i[ADDR_W-1:0];
        len_q  <= h_len_i;
        beat_q <= '0;
      end else if (wr_beat || rd_issue) begin
        addr_q <= addr_q + ADDR_W'(1);
        beat_q <= beat_q + CNT_W'(1);
      end
    end
  end

  // A bank is busy from its grant until the burst reaches DONE.
  always_comb begin
    for (int unsigned b = 0; b < NBANK; b++) begin
      busy[b] = (gnt && (h_bank == BK_W'(b))) ||
                (((state_q == RD) || (state_q == WR)) && (bk_q == BK_W'(b)));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      own_q    <= '0;
      pend_v_q <= '0;
      pend_d_q <= '0;
    end else begin
      for (int unsigned b = 0; b < NBANK; b++) begin
        if (own_wr_i) begin
          if (busy[b]) begin
            pend_v_q[b] <= 1'b1;
            pend_d_q[b] <= own_i[b];
          end else begin
            own_q[b]    <= own_i[b];
            pend_v_q[b] <= 1'b0;
          end
        end else if (pend_v_q[b] && !busy[b]) begin
          own_q[b]    <= pend_d_q[b];
          pend_v_q[b] <= 1'b0;
        end
      end
    end
  end

  // SRAM banks: the owning side gets the single port.
  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_q;
    logic              e_sel;
    logic              en;
    logic              we;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] wd;

    always_comb begin
      e_sel = e_ok && (e_bank == BK_W'(b));
      en    = e_sel || ((wr_beat || rd_issue) && (bk_q == BK_W'(b)));
      we    = e_sel ? e_we_i : wr_beat;
      a     = e_sel ? e_addr_i[ADDR_W-1:0] : addr_q;
      wd    = e_sel ? e_wdata_i : h_wdata_i;
    end

    always_ff @(posedge clk) begin
      if (en) begin
        if (we) mem[a] <= wd;
        else    rd_q   <= mem[a];
      end
    end

    assign bank_rd[b] = rd_q;
  end

  epu_rd_skid #(.W(DATA_W + 1)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (infl_q),
    .push_data ({infl_last_q, bank_rd[bk_q]}),
    .pop       (rd_pop),
    .valid     (sk_valid),
    .data      (sk_data),
    .count     (sk_cnt)
  );

  assign h_rvalid_o = sk_valid;
  assign h_rdata_o  = sk_data[DATA_W-1:0];
  assign h_rlast_o  = sk_valid && sk_data[DATA_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_rvalid_q <= 1'b0;
      e_err_q    <= 1'b0;
      e_bk_q     <= '0;
    end else begin
      e_rvalid_q <= e_ok && !e_we_i;
      e_err_q    <= e_cs_i && !own_q[e_bank];
      e_bk_q     <= e_bank;
    end
  end

  assign e_rvalid_o = e_rvalid_q;
  assign e_err_o    = e_err_q;
  assign e_rdata_o  = e_rvalid_q ? bank_rd[e_bk_q] : '0;
  assign own_o      = own_q;

endmodule
